// File: rtl/adder_share_pkg.sv
// Shared constants and types for the adder-sharing arbiter slice.
//   WORD_W    : datapath width of the shared adder
//   word_t    : one datapath word
//   COUNT_MAX : saturation value of the carry-out event counter
package adder_share_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/ripple_carry_adder_16bit.sv
// Plain 16-bit ripple-carry adder, no carry-in.
//   a, b : operands
//   sum  : a + b modulo 2^16
//   cout : carry out of bit 15
module ripple_carry_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  always_comb begin
    c   = '0;
    sum = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[16];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a wrapping priority pointer.
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req       : request vector
//   enable    : grant allowed this cycle
//   grant     : one-hot grant (zero when disabled or no request)
//   grant_idx : index of the first requester found from the pointer
// The pointer moves to grant_idx+1 (mod NREQ) whenever a grant is issued.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic           found;
  int unsigned    idx;

  // Search pointer, pointer+1, ... with wrap; first hit wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(ptr) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = '0;
    if (enable && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one ripple_carry_adder_16bit among NREQ requesters.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-requester operand valid
//   req_ready   : per-requester accept (one-hot or zero)
//   req_a/req_b : packed operands, requester i at [16*i+15:16*i]
//   rsp_valid   : result register holds a result
//   rsp_ready   : downstream consumes the result
//   rsp_sum     : registered sum
//   rsp_cout    : registered carry-out
//   rsp_id      : requester owning the result
//   cout_count  : saturating count of accepted adds with carry-out
// One add is accepted per cycle whenever the result slot is free or being
// drained in the same cycle, giving 1-per-cycle throughput.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic [IDW-1:0]         rsp_id,
  output logic [WORD_W-1:0]      cout_count
);

  logic            can_accept;
  logic            arb_enable;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            transfer;
  word_t           a_mux;
  word_t           b_mux;
  word_t           add_sum;
  logic            add_cout;

  assign can_accept = !rsp_valid || rsp_ready;
  assign arb_enable = can_accept && !rst;
  assign req_ready  = grant;
  assign transfer   = |grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .enable    (arb_enable),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign a_mux = req_a[WORD_W*gidx +: WORD_W];
  assign b_mux = req_b[WORD_W*gidx +: WORD_W];

  ripple_carry_adder_16bit u_add (
    .a    (a_mux),
    .b    (b_mux),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
      cout_count <= '0;
    end else begin
      if (transfer) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= gidx;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (transfer && add_cout && (cout_count != COUNT_MAX)) begin
        cout_count <= cout_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_sum;
  logic              rsp_cout;
  logic [1:0]        rsp_id;
  logic [15:0]       cout_count;

  adder_share_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .cout_count (cout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_live = 0;
  bit          m_valid;
  bit          m_cout;
  logic [15:0] m_sum;
  int          m_id, m_ptr, m_cnt;
  int          m_g;
  logic [16:0] m_s;

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_cout = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
      m_live  = 1;
    end else if (m_live) begin
      m_g = (!m_valid || rsp_ready) ? pick(req_valid, m_ptr) : -1;
      if (m_g >= 0) begin
        m_s     = {1'b0, req_a[16*m_g +: 16]} + {1'b0, req_b[16*m_g +: 16]};
        m_valid = 1;
        m_sum   = m_s[15:0];
        m_cout  = m_s[16];
        m_id    = m_g;
        m_ptr   = (m_g + 1) % NREQ;
        if (m_s[16] && m_cnt < 65535) m_cnt++;
      end else if (m_valid && rsp_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  int          e_g;
  logic [NREQ-1:0] e_ready;
  always @(negedge clk) begin
    if (m_live) begin
      e_g     = (rst || !(!m_valid || rsp_ready)) ? -1 : pick(req_valid, m_ptr);
      e_ready = (e_g < 0) ? '0 : (NREQ'(1) << e_g);
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("m_rsp_sum", 32'(rsp_sum), 32'(m_sum));
      chk("m_rsp_cout", 32'(rsp_cout), 32'(m_cout));
      chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
      chk("m_cout_count", 32'(cout_count), 32'(m_cnt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  logic [15:0] ca [3] = '{16'hABCD, 16'hFFFF, 16'h7FFF};
  logic [15:0] cb [3] = '{16'hEF01, 16'h0001, 16'h8000};
  logic [15:0] cs [3] = '{16'h9ACE, 16'h0000, 16'hFFFF};
  logic        cc [3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] da [4] = '{16'h0101, 16'h1101, 16'h2101, 16'hF101};
  logic [15:0] db [4] = '{16'h0000, 16'h0011, 16'h0022, 16'h1033};

  initial begin
    rst = 1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1;
    tick(); tick();
    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    chk("rst_cout", 32'(rsp_cout), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_count", 32'(cout_count), 0);
    chk("rst_ready", 32'(req_ready), 0);
    tick();
    rst = 0;

    // Single request from requester 2
    req_valid = 4'b0100; set_op(2, 16'h1234, 16'h5678);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_sum", 32'(rsp_sum), 32'h68AC);
    chk("single_cout", 32'(rsp_cout), 0);
    chk("single_id", 32'(rsp_id), 2);
    chk("single_count", 32'(cout_count), 0);

    // Back-to-back carry cases on requester 0
    tick();
    req_valid = 4'b0001; set_op(0, ca[0], cb[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("carry_ready", 32'(req_ready), 32'h1);
      if (i > 0) begin
        chk("carry_valid", 32'(rsp_valid), 1);
        chk("carry_sum", 32'(rsp_sum), 32'(cs[i-1]));
        chk("carry_cout", 32'(rsp_cout), 32'(cc[i-1]));
      end
      tick();
      if (i < 2) set_op(0, ca[i+1], cb[i+1]);
      else req_valid = '0;
    end
    @(negedge clk);
    chk("carry_valid", 32'(rsp_valid), 1);
    chk("carry_sum", 32'(rsp_sum), 32'(cs[2]));
    chk("carry_cout", 32'(rsp_cout), 32'(cc[2]));
    chk("carry_count", 32'(cout_count), 2);

    // All requesters valid continuously from reset
    tick();
    rst = 1; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, da[i], db[i]);
    tick();
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
      tick();
    end
    rsp_ready = 0;

    // Backpressure: result of requester 3 held (F101+1033 = 1_0134)
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_sum", 32'(rsp_sum), 32'h0134);
      chk("bp_cout", 32'(rsp_cout), 1);
      chk("bp_id", 32'(rsp_id), 3);
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    chk("bp_count", 32'(cout_count), 2);
    tick();
    @(negedge clk);
    chk("bp_reload_id", 32'(rsp_id), 0);
    chk("bp_reload_sum", 32'(rsp_sum), 32'h0101);

    // Reset mid-operation (requester 1 lands, pointer moves to 2)
    tick();
    rst = 1;
    @(negedge clk);
    chk("mid_ready_in_rst", 32'(req_ready), 0);
    chk("mid_pre_id", 32'(rsp_id), 1);
    chk("mid_pre_valid", 32'(rsp_valid), 1);
    tick();
    @(negedge clk);
    chk("mid_valid", 32'(rsp_valid), 0);
    chk("mid_count", 32'(cout_count), 0);
    chk("mid_ready", 32'(req_ready), 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("mid_first_grant", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    chk("mid_first_id", 32'(rsp_id), 0);

    // Saturation of the carry-out counter
    tick();
    rst = 1; req_valid = 4'b0001; set_op(0, 16'hFFFF, 16'h0001);
    tick();
    rst = 0;
    repeat (65534) tick();
    @(negedge clk);
    chk("sat_fffe", 32'(cout_count), 32'hFFFE);
    repeat (3) tick();
    @(negedge clk);
    chk("sat_ffff", 32'(cout_count), 32'hFFFF);
    chk("sat_sum", 32'(rsp_sum), 0);
    chk("sat_cout", 32'(rsp_cout), 1);
    repeat (2) tick();
    @(negedge clk);
    chk("sat_hold", 32'(cout_count), 32'hFFFF);
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one ripple_carry_adder_16bit instance among NREQ independent requesters.
- Round-robin arbitration; one add accepted per cycle; result registered with requester id and handed off on a valid/ready output port.
- Keeps a saturating count of carry-out events for status/debug.
- Sits between multiple datapath clients and the single shared 16-bit adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of requester id; localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*16  packed operand A; requester i at [16*i+15:16*i].
- req_b  input  NREQ*16  packed operand B, same packing.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  downstream consumes the result.
- rsp_sum  output  16  registered sum.
- rsp_cout  output  1  registered carry-out.
- rsp_id  output  IDW  index of the requester that owns the result.
- cout_count  output  16  saturating count of accepted results with cout=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, cout_count=0.
  - Priority pointer = 0.
  - req_ready=0 while rst is high.
  - An in-flight result is discarded. No partial state survives reset.
- Slot free: can_accept = !rsp_valid || rsp_ready. This is combinational and allows back-to-back throughput of 1 per cycle.
- Grant:
  - When can_accept and any req_valid is high, grant the first requester with req_valid set, searching from the pointer upward with wrap (pointer, pointer+1, …, NREQ-1, 0, …).
  - req_ready[g]=1 for the granted g only.
  - req_ready is all-zero when !can_accept or no request is pending.
  - req_ready may depend on req_valid (combinational). Requesters must not make req_valid depend on req_ready.
- Handshake: a transfer occurs on requester i when req_valid[i] && req_ready[i] at a clk edge. A requester holds req_valid, req_a and req_b stable until its transfer.
- Datapath:
  - Granted operands drive the adder through a combinational mux.
  - On transfer, rsp_sum/rsp_cout/rsp_id register the adder outputs and grant index, and rsp_valid becomes 1.
  - Latency is exactly 1 cycle, from transfer edge to rsp_valid.
- Output:
  - rsp_valid && rsp_ready with no new transfer clears rsp_valid.
  - Output and new transfer in the same cycle: the register reloads and rsp_valid stays 1.
  - rsp_* hold stable while rsp_valid && !rsp_ready.
- Pointer:
  - On a transfer to g, pointer <= (g+1) mod NREQ.
  - Without a transfer, the pointer is unchanged.
  - Fairness: a continuously-valid requester is granted within NREQ transfers.
- cout_count increments on each transfer whose adder cout=1. It saturates at 16'hFFFF with no wrap.
- Arithmetic: the sum is modulo 2^16 and cout is bit 16 of the unsigned sum. There is no carry-in.
- Simultaneous events: all-requesters-valid resolves by pointer only. A request arriving in the cycle it is granted is accepted that cycle.

Decomposition:
- Package adder_share_pkg:
  - Constant WORD_W=16.
  - Typedef word_t (logic [15:0]).
  - Constant COUNT_MAX=16'hFFFF.
- One natural sub-module: rr_arbiter, parameterised NREQ.
  - Inputs: req vector, enable.
  - Outputs: one-hot grant, grant index.
  - Owns the pointer state.
- ripple_carry_adder_16bit is instantiated unchanged.

Test Plan:
- Reset then single request: requester 2 sends a=1234, b=5678, rsp_ready=1 → next cycle rsp_valid=1, sum=68AC, cout=0, id=2, cout_count=0.
- Carry cases, requester 0, back-to-back:
  - ABCD+EF01 → sum 9ACE, cout 1.
  - FFFF+0001 → sum 0000, cout 1.
  - 7FFF+8000 → sum FFFF, cout 0.
  - Required: three consecutive rsp_valid cycles and cout_count=2.
- All four requesters valid continuously from reset, rsp_ready=1 → grant order 0,1,2,3,0,…; rsp_id follows the same order one cycle later.
- Backpressure: rsp_ready=0 with a result held → all req_ready=0 and rsp_* stable for 5 cycles. rsp_ready=1 → that cycle a pending request is accepted and the register reloads.
- Reset mid-operation: assert rst while rsp_valid=1 and requests pending → next cycle rsp_valid=0, cout_count=0, pointer=0, req_ready=0. After release, requester 0 is granted first.
- Saturation: force 65537 carry-producing adds (FFFF+0001) → cout_count=FFFF and it stays there.
